// File: rtl/opti_sos_coef_bank_pkg.sv
// Shared constants and state encoding for the biquad coefficient bank.
// Q2.14 reference values, words per stage, and FSM states.
package opti_sos_coef_bank_pkg;

    localparam logic [15:0] Q_ONE = 16'h4000;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;

    localparam int WORDS_PER_STAGE = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    function automatic int frame_words(input int nstages);
        return nstages * WORDS_PER_STAGE;
    endfunction

endpackage

// File: rtl/opti_sos_coef_shadow.sv
// Shadow/active coefficient register pair: word-addressed shadow writes,
// whole-bank copy into the active register on swap.
module opti_sos_coef_shadow
    import opti_sos_coef_bank_pkg::*;
#(
    parameter int NSTAGES = 4,
    parameter int COEF_W  = 16,
    localparam int NW     = frame_words(NSTAGES),
    localparam int IDX_W  = $clog2(NW),
    localparam int BANK_W = NW * COEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              swap_i,
    output logic [BANK_W-1:0] active_o
);

    // Q2.14 unity scaled to the coefficient width (COEF_W >= 16).
    localparam logic [COEF_W-1:0] ONE_W = COEF_W'(32'(Q_ONE) << (COEF_W - 16));

    function automatic logic [BANK_W-1:0] pass_bank();
        logic [BANK_W-1:0] b;
        b = '0;
        for (int s = 0; s < NSTAGES; s++) begin
            b[s*WORDS_PER_STAGE*COEF_W +: COEF_W] = ONE_W;
        end
        return b;
    endfunction

    localparam logic [BANK_W-1:0] RST_BANK = pass_bank();

    logic [BANK_W-1:0] shadow_q;
    logic [BANK_W-1:0] active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (wr_en_i) begin
            shadow_q[wr_idx_i*COEF_W +: COEF_W] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= RST_BANK;
        end else if (swap_i) begin
            active_q <= shadow_q;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/opti_sos_coef_bank.sv
// Double-buffered biquad coefficient bank: frames load into a shadow copy
// and swap into the active bank only between filter samples.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | waiting for a word with cfg_sof to open a frame
//   ST_LOAD    | frame open, counter holds next shadow slot
//   ST_PENDING | full frame in shadow, waiting for data_valid_in low
module opti_sos_coef_bank
    import opti_sos_coef_bank_pkg::*;
#(
    parameter int NSTAGES = 4,
    parameter int COEF_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_valid,
    input  logic                            cfg_sof,
    input  logic [COEF_W-1:0]               cfg_data,
    output logic                            cfg_ready,
    input  logic                            data_valid_in,
    output logic [NSTAGES*5*COEF_W-1:0]     coef_out,
    output logic                            coef_update,
    output logic                            cfg_err
);

    localparam int NW    = frame_words(NSTAGES);
    localparam int IDX_W = $clog2(NW);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             err_q, err_d;
    logic             upd_q;

    logic             accept;
    logic             last_word;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             swap;

    assign accept    = cfg_valid && ready_q;
    assign last_word = (cnt_q == IDX_W'(NW - 1));

    // ready is registered from the next state so it is low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != ST_PENDING);
            err_q   <= err_d;
            upd_q   <= swap;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && cfg_sof) begin
                    state_d = ST_LOAD;
                    cnt_d   = IDX_W'(1);
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cfg_sof) begin
                        cnt_d = IDX_W'(1);
                    end else if (last_word) begin
                        state_d = ST_PENDING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (!data_valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = cnt_q;
        swap   = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cfg_sof) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (cfg_sof) begin
                        wr_idx = '0;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                swap = !data_valid_in;
            end
            default: begin
                swap = 1'b0;
            end
        endcase
    end

    opti_sos_coef_shadow #(
        .NSTAGES (NSTAGES),
        .COEF_W  (COEF_W)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (cfg_data),
        .swap_i    (swap),
        .active_o  (coef_out)
    );

    assign cfg_ready   = ready_q;
    assign coef_update = upd_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_opti_sos_coef_bank.sv
// Directed and random stimulus against a frame-level reference model of the
// coefficient bank; every output is compared after each clock edge.
module tb_opti_sos_coef_bank;

    localparam int NS = 4;
    localparam int CW = 16;
    localparam int NW = NS * 5;
    localparam int BW = NW * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_sof;
    logic [CW-1:0] cfg_data;
    logic          cfg_ready;
    logic          data_valid_in;
    logic [BW-1:0] coef_out;
    logic          coef_update;
    logic          cfg_err;

    always #5 clk = ~clk;

    opti_sos_coef_bank #(.NSTAGES(NS), .COEF_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_sof       (cfg_sof),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .data_valid_in (data_valid_in),
        .coef_out      (coef_out),
        .coef_update   (coef_update),
        .cfg_err       (cfg_err)
    );

    // Reference model: active bank as a word array, open frame as a queue.
    logic [CW-1:0] m_active [NW];
    logic [CW-1:0] m_frame  [$];
    bit            m_in_frame;
    bit            m_pending;
    bit            m_armed;
    bit            e_err;
    bit            e_upd;

    int checks = 0;
    int errors = 0;

    function automatic logic [BW-1:0] exp_bank();
        logic [BW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*CW +: CW] = m_active[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NW; i++) m_active[i] = (i % 5 == 0) ? 16'h4000 : 16'h0000;
        m_frame.delete();
        m_in_frame = 0;
        m_pending  = 0;
        m_armed    = 0;
        e_err      = 0;
        e_upd      = 0;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs now applied, then compare.
    task automatic cycle();
        bit acc;
        acc   = cfg_valid && m_armed && !m_pending && rst_n;
        e_upd = 0;
        e_err = 0;
        if (rst_n) begin
            if (m_pending && !data_valid_in) begin
                for (int i = 0; i < NW; i++) m_active[i] = m_frame[i];
                m_frame.delete();
                m_pending = 0;
                e_upd     = 1;
            end
            if (acc) begin
                if (cfg_sof) begin
                    e_err = m_in_frame;
                    m_frame.delete();
                    m_frame.push_back(cfg_data);
                    m_in_frame = 1;
                end else if (!m_in_frame) begin
                    e_err = 1;
                end else begin
                    m_frame.push_back(cfg_data);
                end
                if (m_in_frame && m_frame.size() == NW) begin
                    m_pending  = 1;
                    m_in_frame = 0;
                end
            end
            m_armed = 1;
        end else begin
            m_reset();
        end
        @(posedge clk);
        #1;
        chk("coef_out",    coef_out,    exp_bank());
        chk("cfg_ready",   BW'(cfg_ready),   BW'(m_armed && !m_pending));
        chk("coef_update", BW'(coef_update), BW'(e_upd));
        chk("cfg_err",     BW'(cfg_err),     BW'(e_err));
    endtask

    task automatic send(input logic [CW-1:0] d, input bit sof, input bit dvi);
        cfg_valid     = 1'b1;
        cfg_sof       = sof;
        cfg_data      = d;
        data_valid_in = dvi;
        cycle();
        cfg_valid = 1'b0;
        cfg_sof   = 1'b0;
    endtask

    task automatic idle(input int n, input bit dvi);
        cfg_valid     = 1'b0;
        cfg_sof       = 1'b0;
        data_valid_in = dvi;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_reset_bank", coef_out, exp_bank());
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(1, 1'b0);
    endtask

    task automatic send_frame(input bit dvi);
        for (int i = 0; i < NW; i++) send(CW'($urandom), i == 0, dvi);
    endtask

    initial begin
        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_sof       = 1'b0;
        cfg_data      = '0;
        data_valid_in = 1'b0;
        m_reset();

        // Reset state, then ready rises after release.
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(2, 1'b0);
        chk("reset_passthru", coef_out, {NS{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000}});

        // Counting frame 1..20 with the cascade idle.
        for (int i = 0; i < NW; i++) send(CW'(i + 1), i == 0, 1'b0);
        idle(3, 1'b0);
        chk("s0_b0", BW'(coef_out[15:0]),    BW'(16'h0001));
        chk("s3_a2", BW'(coef_out[319:304]), BW'(16'h0014));

        // Frame completed while samples stream: swap waits for the gap.
        send_frame(1'b1);
        idle(10, 1'b1);
        idle(3, 1'b0);

        // Boundary-value words pass bit-exact.
        send(16'h7FFF, 1'b1, 1'b0);
        send(16'h8000, 1'b0, 1'b0);
        for (int i = 2; i < NW; i++) send((i % 2) ? 16'hFFFF : 16'h0000, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Stray sof on word 7 restarts the frame.
        for (int i = 0; i < 6; i++) send(CW'($urandom), i == 0, 1'b0);
        send_frame(1'b0);
        idle(3, 1'b0);

        // Word without sof while idle is dropped.
        send(CW'($urandom), 1'b0, 1'b0);
        idle(3, 1'b0);

        // Reset mid-load, then a clean frame.
        for (int i = 0; i < 12; i++) send(CW'($urandom), i == 0, 1'b0);
        do_reset();
        send_frame(1'b0);
        idle(3, 1'b0);

        // Reset while a swap is pending.
        send_frame(1'b1);
        idle(2, 1'b1);
        do_reset();
        idle(3, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cfg_valid     = ($urandom_range(0, 3) != 0);
            cfg_sof       = ($urandom_range(0, 23) == 0);
            cfg_data      = CW'($urandom);
            data_valid_in = ($urandom_range(0, 1) == 0);
            cycle();
        end
        idle(3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
